// File: rtl/phi2_phase_tracker_if.sv
// Recovered-phase output bundle of the PHI2 phase tracker.
// master: tracker drives q/p, edge pulses, lock status and period; slave: consumers.
interface phi2_phase_tracker_if;
    logic [1:0] q;
    logic       p;
    logic       phi2_rise;
    logic       phi2_fall;
    logic       locked;
    logic       period_err;
    logic [7:0] period;

    modport master (
        output q,
        output p,
        output phi2_rise,
        output phi2_fall,
        output locked,
        output period_err,
        output period
    );

    modport slave (
        input q,
        input p,
        input phi2_rise,
        input phi2_fall,
        input locked,
        input period_err,
        input period
    );
endinterface

// File: rtl/phi2_phase_tracker.sv
// Follows an external PHI2: synchronizes it, measures its period, recovers q/p phase.
// Ports: fclk, reset_n (async low), phi2_in (async), bus (master: q,p,edges,lock,period).
module phi2_phase_tracker #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_HALF    = 15,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                  fclk,
    input  logic                  reset_n,
    input  logic                  phi2_in,
    phi2_phase_tracker_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        LOCKED
    } state_t;

    localparam logic [6:0] RUN_MAX = 7'(MAX_HALF);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_COUNT);

    state_t state;
    state_t state_nx;

    logic [SYNC_STAGES-1:0] sync;
    logic       s;
    logic       s_d;
    logic       rise;
    logic       fall;
    logic       any_edge;

    logic [6:0] run;
    logic [6:0] high_len;
    logic       seen_fall;
    logic       pv;
    logic [3:0] match_cnt;
    logic [3:0] match_inc;
    logic [3:0] match_nx;
    logic [7:0] new_period;
    logic       meas;
    logic       same;
    logic       sat;
    logic       clr;
    logic       locked_nx;
    logic       err_nx;

    logic [1:0] q_r;
    logic       p_r;
    logic       rise_r;
    logic       fall_r;
    logic       locked_r;
    logic       err_r;
    logic [7:0] period_r;

    assign s        = sync[SYNC_STAGES-1];
    assign rise     = s & ~s_d;
    assign fall     = ~s & s_d;
    assign any_edge = rise | fall;

    // Pre-clear run is the length of the level that just ended.
    assign new_period = {1'b0, high_len} + {1'b0, run};
    assign match_inc  = (match_cnt == 4'hF) ? match_cnt : match_cnt + 4'd1;
    assign same       = pv && (new_period == period_r);
    assign match_nx   = same ? match_inc : 4'd0;
    assign meas       = rise && seen_fall && (state != IDLE);
    assign sat        = (run == RUN_MAX) && !any_edge;

    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], phi2_in};
            s_d  <= s;
        end
    end

    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            run <= 7'd0;
        end else if (any_edge) begin
            run <= 7'd1;
        end else if (run != RUN_MAX) begin
            run <= run + 7'd1;
        end
    end

    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        locked_nx = locked_r;
        err_nx    = 1'b0;
        clr       = 1'b0;
        unique case (state)
            IDLE: begin
                // First edge only arms tracking; nothing is measured on it.
                if (any_edge) begin
                    state_nx = TRACK;
                    clr      = 1'b1;
                end
            end
            TRACK: begin
                if (sat) begin
                    state_nx  = IDLE;
                    clr       = 1'b1;
                    locked_nx = 1'b0;
                end else if (meas && same && match_inc == LOCK_N) begin
                    state_nx  = LOCKED;
                    locked_nx = 1'b1;
                end
            end
            LOCKED: begin
                if (sat) begin
                    state_nx  = IDLE;
                    clr       = 1'b1;
                    locked_nx = 1'b0;
                    err_nx    = 1'b1;
                end else if (meas && !same) begin
                    state_nx  = TRACK;
                    locked_nx = 1'b0;
                    err_nx    = 1'b1;
                end
            end
            default: begin
                state_nx  = IDLE;
                clr       = 1'b1;
                locked_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            high_len  <= 7'd0;
            seen_fall <= 1'b0;
            pv        <= 1'b0;
            match_cnt <= 4'd0;
            period_r  <= 8'd0;
        end else if (clr) begin
            seen_fall <= 1'b0;
            pv        <= 1'b0;
            match_cnt <= 4'd0;
        end else begin
            if (fall) begin
                high_len  <= run;
                seen_fall <= 1'b1;
            end
            if (meas) begin
                period_r  <= new_period;
                pv        <= 1'b1;
                seen_fall <= 1'b0;
                match_cnt <= match_nx;
            end
        end
    end

    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            q_r      <= 2'd0;
            p_r      <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
            locked_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            rise_r   <= rise;
            fall_r   <= fall;
            locked_r <= locked_nx;
            err_r    <= err_nx;
            if (rise) begin
                q_r <= 2'd2;
                p_r <= 1'b1;
            end else if (fall) begin
                q_r <= 2'd0;
                p_r <= 1'b0;
            end else begin
                q_r <= q_r + 2'd1;
            end
        end
    end

    assign bus.q          = q_r;
    assign bus.p          = p_r;
    assign bus.phi2_rise  = rise_r;
    assign bus.phi2_fall  = fall_r;
    assign bus.locked     = locked_r;
    assign bus.period_err = err_r;
    assign bus.period     = period_r;

endmodule

// File: tb/tb_phi2_phase_tracker.sv
// Directed bench for phi2_phase_tracker: vector table plus multi-cycle sequences.
// Drives phi2_in per fclk cycle and checks edges, phase, lock and period.
module tb_phi2_phase_tracker;

    logic fclk = 1'b0;
    logic reset_n;
    logic phi2_in;

    phi2_phase_tracker_if bus ();

    phi2_phase_tracker #(
        .SYNC_STAGES(2),
        .MAX_HALF(15),
        .LOCK_COUNT(4)
    ) dut (
        .fclk(fclk),
        .reset_n(reset_n),
        .phi2_in(phi2_in),
        .bus(bus)
    );

    always #5 fclk = ~fclk;

    typedef struct {
        logic        phi;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[24];

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int nr;
    int ne;
    int err_rise;
    int err_gap;
    int err_lk;
    int last_edge = 0;
    int lk_at[17];
    int per_at[17];
    logic [1:0] qh0, qh1, qh2;
    logic       ph0, ph1, ph2;
    logic [7:0] fq;
    logic [3:0] fp;

    function automatic vec_t mk(logic phi, logic r, logic f, logic [1:0] q,
                                logic p, logic l, logic e, logic [7:0] per);
        vec_t v;
        v.phi = phi;
        v.exp = {r, f, q, p, l, e, per};
        return v;
    endfunction

    function automatic logic [14:0] outs();
        return {bus.phi2_rise, bus.phi2_fall, bus.q, bus.p,
                bus.locked, bus.period_err, bus.period};
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        nr       = 0;
        ne       = 0;
        err_rise = 0;
        err_gap  = -1;
        err_lk   = -1;
        for (int i = 0; i < 17; i++) begin
            lk_at[i]  = -1;
            per_at[i] = -1;
        end
    endtask

    task automatic step(logic v);
        phi2_in = v;
        @(posedge fclk);
        #1;
        cyc++;
        if (bus.period_err) begin
            ne++;
            err_rise = nr + (bus.phi2_rise ? 1 : 0);
            err_gap  = cyc - last_edge;
            err_lk   = bus.locked;
        end
        if (bus.phi2_rise) begin
            nr++;
            if (nr < 17) begin
                lk_at[nr]  = bus.locked;
                per_at[nr] = bus.period;
            end
        end
        if (bus.phi2_fall) begin
            fq = {qh2, qh1, qh0, bus.q};
            fp = {ph2, ph1, ph0, bus.p};
        end
        if (bus.phi2_rise || bus.phi2_fall) last_edge = cyc;
        qh2 = qh1; qh1 = qh0; qh0 = bus.q;
        ph2 = ph1; ph1 = ph0; ph0 = bus.p;
    endtask

    task automatic hold(logic v, int n);
        repeat (n) step(v);
    endtask

    task automatic toggle(int hi, int lo, int n);
        repeat (n) begin
            repeat (hi) step(1'b1);
            repeat (lo) step(1'b0);
        end
    endtask

    task automatic run_table(string tag);
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].phi);
            chk($sformatf("%s_vec%0d", tag, i), int'(outs()), int'(tbl[i].exp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //           phi r f q p l e per
        tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 2, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 2, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 3, 1, 0, 0, 0);
        tbl[4]  = mk(1, 0, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 2, 1, 0, 0, 4);
        tbl[7]  = mk(0, 0, 0, 3, 1, 0, 0, 4);
        tbl[8]  = mk(1, 0, 1, 0, 0, 0, 0, 4);
        tbl[9]  = mk(1, 0, 0, 1, 0, 0, 0, 4);
        tbl[10] = mk(0, 1, 0, 2, 1, 0, 0, 4);
        tbl[11] = mk(0, 0, 0, 3, 1, 0, 0, 4);
        tbl[12] = mk(1, 0, 1, 0, 0, 0, 0, 4);
        tbl[13] = mk(1, 0, 0, 1, 0, 0, 0, 4);
        tbl[14] = mk(0, 1, 0, 2, 1, 0, 0, 4);
        tbl[15] = mk(0, 0, 0, 3, 1, 0, 0, 4);
        tbl[16] = mk(1, 0, 1, 0, 0, 0, 0, 4);
        tbl[17] = mk(1, 0, 0, 1, 0, 0, 0, 4);
        tbl[18] = mk(0, 1, 0, 2, 1, 0, 0, 4);
        tbl[19] = mk(0, 0, 0, 3, 1, 0, 0, 4);
        tbl[20] = mk(1, 0, 1, 0, 0, 0, 0, 4);
        tbl[21] = mk(1, 0, 0, 1, 0, 0, 0, 4);
        tbl[22] = mk(0, 1, 0, 2, 1, 1, 0, 4);
        tbl[23] = mk(0, 0, 0, 3, 1, 1, 0, 4);

        qh0 = 0; qh1 = 0; qh2 = 0;
        ph0 = 0; ph1 = 0; ph2 = 0;
        fq = 0; fp = 0;
        clear_mon();

        phi2_in = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge fclk);
        #1;
        chk("reset_outs", int'(outs()), 0);
        @(negedge fclk);
        reset_n = 1'b1;

        // Symmetric 2/2 acquisition, lock on rise 6.
        run_table("acq");

        // Period change 4 -> 6 while locked.
        clear_mon();
        toggle(3, 3, 8);
        chk("chg_r1_per", per_at[1], 4);
        chk("chg_r1_lk", lk_at[1], 1);
        chk("chg_err_n", ne, 1);
        chk("chg_err_rise", err_rise, 2);
        chk("chg_r2_per", per_at[2], 6);
        chk("chg_r2_lk", lk_at[2], 0);
        chk("chg_r5_lk", lk_at[5], 0);
        chk("chg_r6_lk", lk_at[6], 1);

        // Stuck high while locked: loss of lock 15 cycles after last edge.
        clear_mon();
        hold(1'b1, 20);
        chk("hi_err_n", ne, 1);
        chk("hi_err_gap", err_gap, 15);
        chk("hi_err_lk", err_lk, 0);
        chk("hi_lk", bus.locked, 0);
        chk("hi_per_hold", bus.period, 6);

        // Saturation while tracking but unlocked: silent drop to IDLE.
        clear_mon();
        toggle(3, 3, 3);
        hold(1'b0, 20);
        chk("trk_err_n", ne, 0);
        chk("trk_lk", bus.locked, 0);

        // Reacquire from IDLE: first rise only arms, lock on rise 6.
        clear_mon();
        toggle(3, 3, 8);
        chk("re_r1_per", per_at[1], 6);
        chk("re_r2_per", per_at[2], 6);
        chk("re_r5_lk", lk_at[5], 0);
        chk("re_r6_lk", lk_at[6], 1);
        chk("re_err_n", ne, 0);

        // Asymmetric 3 high / 1 low.
        clear_mon();
        toggle(3, 1, 12);
        chk("asy_err_n", ne, 1);
        chk("asy_err_rise", err_rise, 2);
        chk("asy_r2_per", per_at[2], 4);
        chk("asy_r5_lk", lk_at[5], 0);
        chk("asy_r6_lk", lk_at[6], 1);
        chk("asy_per", bus.period, 4);
        chk("asy_q_seq", fq, 8'b10_11_00_00);
        chk("asy_p_seq", fp, 4'b1110);

        // Asynchronous reset mid-stream while locked.
        step(1'b1);
        chk("pre_rst_lk", bus.locked, 1);
        #2;
        reset_n = 1'b0;
        phi2_in = 1'b0;
        #1;
        chk("async_rst_outs", int'(outs()), 0);
        repeat (2) @(posedge fclk);
        @(negedge fclk);
        reset_n = 1'b1;
        run_table("reacq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
